// File: rtl/led_pwm_dimmer_if.sv
// ----------------------------------------------------------------------------
// led_pwm_dimmer_if
//   Signal bundle between the light-stand up/down FSM (master side) and the
//   LED PWM dimmer (slave side).
//
//   i_lightState  3         light level 0..4 from the up/down FSM
//   o_led         1         registered PWM drive for the LED pin
//   o_duty        PWM_BITS  duty currently applied after ramping
//   o_busy        1         high while the dimmer is fading
// ----------------------------------------------------------------------------
interface led_pwm_dimmer_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          i_lightState;
    logic                o_led;
    logic [PWM_BITS-1:0] o_duty;
    logic                o_busy;

    modport master (
        output i_lightState,
        input  o_led,
        input  o_duty,
        input  o_busy
    );

    modport slave (
        input  i_lightState,
        output o_led,
        output o_duty,
        output o_busy
    );
endinterface

// File: rtl/led_pwm_dimmer.sv
// ----------------------------------------------------------------------------
// led_pwm_dimmer
//   Maps the light level (0..4) to a target duty, fades the applied duty
//   toward that target in STEP-sized increments every RAMP_DIV clocks, and
//   drives the LED with a period-aligned, glitch-free PWM.
//
//   i_clk      in   system clock, rising edge
//   i_reset_n  in   synchronous reset, active-low
//   bus        slave modport of led_pwm_dimmer_if
//                i_lightState in, o_led / o_duty / o_busy out
// ----------------------------------------------------------------------------
module led_pwm_dimmer #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 1024,
    parameter int STEP     = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    led_pwm_dimmer_if.slave   bus
);

    localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] QTR      = PWM_BITS'(1) << (PWM_BITS - 2);
    localparam logic [TW-1:0]       TICK_AT  = TW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_e;

    state_e              state_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] latched_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic [TW-1:0]       timer_q;
    logic                led_q;

    logic [PWM_BITS-1:0] target_d;
    logic [PWM_BITS-1:0] up_duty_d;
    logic [PWM_BITS-1:0] dn_duty_d;
    logic [PWM_BITS:0]   up_gap;
    logic [PWM_BITS:0]   dn_gap;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   dn_sum;
    logic                tick;

    // Target duty for the requested level; illegal levels turn the LED off.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        target_d = '0;
        case (bus.i_lightState)
            3'd1:    target_d = QTR;
            3'd2:    target_d = QTR << 1;
            3'd3:    target_d = QTR + (QTR << 1);
            3'd4:    target_d = DUTY_MAX;
            default: target_d = '0;
        endcase
    end

    // One-bit-wider step arithmetic; the clamp to target keeps the result
    // inside [0, DUTY_MAX], so the truncating casts below never wrap.
    always_comb begin
        up_gap    = {1'b0, target_d} - {1'b0, duty_q};
        dn_gap    = {1'b0, duty_q} - {1'b0, target_d};
        up_sum    = {1'b0, duty_q} + STEP_EXT;
        dn_sum    = {1'b0, duty_q} - STEP_EXT;
        up_duty_d = (up_gap <= STEP_EXT) ? target_d : up_sum[PWM_BITS-1:0];
        dn_duty_d = (dn_gap <= STEP_EXT) ? target_d : dn_sum[PWM_BITS-1:0];
    end

    assign tick = (timer_q == TICK_AT);

    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge only (synchronous), and
        // all state uses non-blocking assignments so every register sees the
        // pre-edge values of the others.
        if (!i_reset_n) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            latched_q <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            led_q     <= 1'b0;
        end else begin
            // PWM: duty is only picked up at the period boundary so a fade
            // step never shortens or stretches the period in progress.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == DUTY_MAX) begin
                latched_q <= duty_q;
            end
            // Full-scale duty forces a constant high (no one-clock dropout
            // at cnt == DUTY_MAX).
            led_q <= (latched_q == DUTY_MAX) || (cnt_q < latched_q);

            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (target_d > duty_q) begin
                        state_q <= RAMP_UP;
                    end else if (target_d < duty_q) begin
                        state_q <= RAMP_DOWN;
                    end
                end

                RAMP_UP, RAMP_DOWN: begin
                    if (target_d == duty_q) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= tick ? '0 : timer_q + 1'b1;
                        // The step follows the current state; if the target
                        // has just crossed to the other side, the step is
                        // suppressed rather than moving away from it.
                        if (tick) begin
                            if (state_q == RAMP_UP && target_d > duty_q) begin
                                duty_q <= up_duty_d;
                            end else if (state_q == RAMP_DOWN && target_d < duty_q) begin
                                duty_q <= dn_duty_d;
                            end
                        end
                        // Direction swap keeps the timer running so the
                        // next tick stays on the original cadence.
                        state_q <= (target_d > duty_q) ? RAMP_UP : RAMP_DOWN;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign bus.o_led  = led_q;
    assign bus.o_duty = duty_q;
    assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// ----------------------------------------------------------------------------
// tb_led_pwm_dimmer
//   Directed bench for led_pwm_dimmer: a STEP=8 / RAMP_DIV=4 instance for the
//   main behaviour and a STEP=100 instance for the clamped large-step fade.
//   Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_led_pwm_dimmer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_pwm_dimmer_if #(.PWM_BITS(8)) bus  ();
    led_pwm_dimmer_if #(.PWM_BITS(8)) bus2 ();

    led_pwm_dimmer #(.PWM_BITS(8), .RAMP_DIV(4), .STEP(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    led_pwm_dimmer #(.PWM_BITS(8), .RAMP_DIV(4), .STEP(100)) dut2 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] level;
        int         exp_duty;
        int         exp_ticks;   // ramp steps needed from the previous duty
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.o_busy && cycles < budget);
    endtask

    task automatic wait_duty(input int value, input int budget, output int cycles);
        cycles = 0;
        while (int'(bus.o_duty) != value && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_lightState  = 3'd0;
        bus2.i_lightState = 3'd0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int c, prev, last_change, bad, highs, rises, run, longest;
        logic prev_led;

        // Table: each level applied from the duty left by the row before.
        // Entry clock + 4 clocks per step + 1 clock to drop busy.
        vecs[0] = '{3'd7,   0, 16};   // 128 -> 0, illegal level
        vecs[1] = '{3'd1,  64,  8};
        vecs[2] = '{3'd3, 192, 16};
        vecs[3] = '{3'd2, 128,  8};
        vecs[4] = '{3'd4, 255, 16};   // 15 full steps + clamped 7
        vecs[5] = '{3'd5,   0, 32};   // 31 full steps + clamped 7

        // ---- reset held with level 4, then release ----
        rst_n = 1'b0;
        bus.i_lightState  = 3'd4;
        bus2.i_lightState = 3'd0;
        step(3);
        check("reset_led",  int'(bus.o_led),  0);
        check("reset_duty", int'(bus.o_duty), 0);
        check("reset_busy", int'(bus.o_busy), 0);
        rst_n = 1'b1;
        step(1);
        check("release_busy", int'(bus.o_busy), 1);
        do_reset();

        // ---- 0 -> level 2: +8 every 4 clocks, 128 after 16 steps ----
        bus.i_lightState = 3'd2;
        c = 0; prev = 0; last_change = 1; bad = 0;
        while (int'(bus.o_duty) != 128 && c < 100) begin
            step(1);
            c++;
            if (int'(bus.o_duty) > 128) bad++;
            if (int'(bus.o_duty) != prev) begin
                if (int'(bus.o_duty) - prev != 8 || c - last_change != 4) bad++;
                prev = int'(bus.o_duty);
                last_change = c;
            end
        end
        check("up_reach_clks", c, 65);
        check("up_step_shape", bad, 0);
        check("up_busy_at_top", int'(bus.o_busy), 1);
        step(1);
        check("up_busy_drop", int'(bus.o_busy), 0);
        step(4);
        check("up_hold_128", int'(bus.o_duty), 128);

        // ---- table: level -> settled duty and fade length ----
        for (int i = 0; i < 6; i++) begin
            bus.i_lightState = vecs[i].level;
            wait_idle(400, c);
            check($sformatf("vec%0d_clks", i), c, 4 * vecs[i].exp_ticks + 2);
            check($sformatf("vec%0d_duty", i), int'(bus.o_duty), vecs[i].exp_duty);
        end

        // ---- PWM shape: duty 64 ----
        bus.i_lightState = 3'd1;
        wait_idle(400, c);
        check("pwm64_idle", int'(bus.o_busy), 0);
        step(512);
        highs = 0; rises = 0; run = 0; longest = 0;
        prev_led = bus.o_led;
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (bus.o_led) begin
                highs++;
                run++;
                if (!prev_led) rises++;
                if (run > longest) longest = run;
            end else begin
                run = 0;
            end
            prev_led = bus.o_led;
        end
        check("pwm64_highs", highs, 128);
        check("pwm64_pulses", rises, 2);
        check("pwm64_width", longest, 64);

        // ---- PWM: duty 0 never high ----
        bus.i_lightState = 3'd0;
        wait_idle(400, c);
        step(512);
        highs = 0;
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (bus.o_led) highs++;
        end
        check("pwm0_highs", highs, 0);

        // ---- PWM: full scale constant high over 3 periods ----
        bus.i_lightState = 3'd4;
        wait_idle(400, c);
        check("pwm255_duty", int'(bus.o_duty), 255);
        step(512);
        highs = 0;
        for (int i = 0; i < 768; i++) begin
            step(1);
            if (bus.o_led) highs++;
        end
        check("pwm255_highs", highs, 768);

        // ---- reversal mid-ramp at duty 40, tick cadence unchanged ----
        do_reset();
        bus.i_lightState = 3'd2;
        wait_duty(40, 100, c);
        check("rev_reach_40", c, 21);
        bus.i_lightState = 3'd0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("rev_duty_c%0d", k), int'(bus.o_duty), 40 - 8 * (k / 4));
        end
        check("rev_busy_at_0", int'(bus.o_busy), 1);
        step(1);
        check("rev_idle", int'(bus.o_busy), 0);

        // ---- reset mid-ramp at duty 72 ----
        do_reset();
        bus.i_lightState = 3'd2;
        wait_duty(72, 100, c);
        check("abort_reach_72", c, 37);
        rst_n = 1'b0;
        step(1);
        check("abort_duty", int'(bus.o_duty), 0);
        check("abort_led",  int'(bus.o_led),  0);
        check("abort_busy", int'(bus.o_busy), 0);

        // ---- STEP=100 instance: 0 -> 100, 200, 255 ----
        bus.i_lightState  = 3'd0;
        bus2.i_lightState = 3'd0;
        step(1);
        rst_n = 1'b1;
        step(1);
        bus2.i_lightState = 3'd4;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            if (k == 4)  check("big_c4",  int'(bus2.o_duty), 0);
            if (k == 5)  check("big_c5",  int'(bus2.o_duty), 100);
            if (k == 9)  check("big_c9",  int'(bus2.o_duty), 200);
            if (k == 13) check("big_c13", int'(bus2.o_duty), 255);
            if (k == 13) check("big_busy13", int'(bus2.o_busy), 1);
            if (k == 14) check("big_busy14", int'(bus2.o_busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
